// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (also used by the ALU controller),
// the sequencing FSM state encoding, and a helper that identifies the
// operations routed through the serial shifter.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SRA = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_SLT = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  // True for the operations handled by the 1-bit-per-cycle shifter.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-step ALU datapath: logic, add/sub, BEQ compare and signed SLT.
// Purely combinational; shift codes and unknown codes produce zero here,
// the top level supplies shift results itself.
module alu_comb
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  logic slt;

  // Select the single-cycle result; carries and overflow are dropped.
  always_comb begin
    y_o = '0;
    slt = ($signed(a_i) < $signed(b_i));
    case (op_i)
      OP_AND:         y_o = a_i & b_i;
      OP_OR:          y_o = a_i | b_i;
      OP_XOR:         y_o = a_i ^ b_i;
      OP_ADD:         y_o = a_i + b_i;
      OP_SUB, OP_BEQ: y_o = a_i - b_i;
      OP_SLT:         y_o = {{(DATA_W-1){1'b0}}, slt};
      default:        y_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-step ops finish in one cycle, shifts run serially
// one bit per cycle (shamt+1 cycles). busy is high while shifting; starts seen
// then are dropped, and a start in the done cycle is accepted back-to-back.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  alu_state_e          state_q, state_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  alu_op_e             op_q, op_d;
  logic [DATA_W-1:0]   res_q, res_d;

  logic [DATA_W-1:0]   comb_res;
  logic [DATA_W-1:0]   shifted;
  logic [SHAMT_W-1:0]  shamt;
  logic                shift_req;

  alu_comb #(
    .DATA_W (DATA_W)
  ) u_alu_comb (
    .op_i (Operation),
    .a_i  (SrcA),
    .b_i  (SrcB),
    .y_o  (comb_res)
  );

  assign shamt     = SrcB[SHAMT_W-1:0];
  assign shift_req = is_shift_op(Operation);

  // One-bit shift of the working register according to the captured op.
  always_comb begin
    shifted = sh_q;
    case (op_q)
      OP_SLL:  shifted = {sh_q[DATA_W-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, sh_q[DATA_W-1:1]};
      OP_SRA:  shifted = {sh_q[DATA_W-1], sh_q[DATA_W-1:1]};
      default: shifted = sh_q;
    endcase
  end

  // Sequencing: accept in IDLE or DONE, iterate in SHIFT, pulse DONE once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (shift_req && (shamt != '0)) begin
            sh_d    = SrcA;
            op_d    = alu_op_e'(Operation);
            cnt_d   = shamt;
            state_d = SHIFT;
          end else begin
            // A zero-length shift is just SrcA passed through.
            res_d   = shift_req ? SrcA : comb_res;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        sh_d  = shifted;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          res_d   = shifted;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any shift in flight without a done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      op_q    <= OP_AND;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign ALUResult = res_q;
  assign Zero      = (res_q == '0);

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: directed operations push expected
// result, latency and busy length; a negedge monitor checks each done.
module tb_multicycle_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] alu_result;
  logic        zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          busy_len;
    int          due;
  } exp_t;

  exp_t sb[$];

  multicycle_alu #(.DATA_W(32)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .Operation (op),
    .SrcA      (src_a),
    .SrcB      (src_b),
    .busy      (busy),
    .done      (done),
    .ALUResult (alu_result),
    .Zero      (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every completion against the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done at cycle %0d result %h", cyc, alu_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (alu_result !== e.res) begin
          errors++;
          $display("FAIL %s result got %h want %h", e.name, alu_result, e.res);
        end
        checks++;
        if (zero !== (e.res == 32'd0)) begin
          errors++;
          $display("FAIL %s zero got %b want %b", e.name, zero, (e.res == 32'd0));
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL %s done_cycle got %0d want %0d", e.name, cyc, e.due);
        end
        checks++;
        if (busy_cnt != e.busy_len) begin
          errors++;
          $display("FAIL %s busy_cycles got %0d want %0d", e.name, busy_cnt, e.busy_len);
        end
      end
      busy_cnt = 0;
    end
  end

  // Drive a request at the current negedge and record its expectation.
  task automatic send(input string name, input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] res, input int lat);
    exp_t e;
    start = 1'b1; op = o; src_a = a; src_b = b;
    e.name = name; e.res = res; e.busy_len = lat - 1; e.due = cyc + lat;
    sb.push_back(e);
  endtask

  // Wait (bounded) for every outstanding expectation to be consumed.
  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s timeout pending %0d want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input string name, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] res, input int lat);
    send(name, o, a, b, res, lat);
    @(negedge clk);
    start = 1'b0;
    drain(name);
    @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL %s busy/done/result/zero got %b/%b/%h/%b want 0/0/00000000/1",
               name, busy, done, alu_result, zero);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 4'b0000; src_a = '0; src_b = '0;
    #3;
    check_idle("reset_state");
    @(negedge clk);
    @(negedge clk);
    check_idle("reset_hold");
    rst_n = 1'b1;
    @(negedge clk);

    // Single-cycle operations and boundary values.
    run("add_5_7",   OP_ADD, 32'd5,          32'd7,          32'd12,         1);
    run("beq_eq",    OP_BEQ, 32'h0000_1234,  32'h0000_1234,  32'd0,          1);
    run("slt_neg",   OP_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          1);
    run("slt_pos",   OP_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0,          1);
    run("and",       OP_AND, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234,  1);
    run("or",        OP_OR,  32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  1);
    run("xor",       OP_XOR, 32'hFFFF_0000,  32'hFF00_FF00,  32'h00FF_FF00,  1);
    run("sub_neg",   OP_SUB, 32'd3,          32'd5,          32'hFFFF_FFFE,  1);
    run("add_wrap",  OP_ADD, 32'hFFFF_FFFF,  32'd2,          32'd1,          1);
    run("bad_op",    4'b1111, 32'hDEAD_BEEF, 32'h1234_5678,  32'd0,          1);

    // Serial shifts: latency is shamt+1, busy for shamt cycles.
    run("sra_4",     OP_SRA, 32'h8000_0000,  32'd4,          32'hF800_0000,  5);
    run("srl_4",     OP_SRL, 32'h8000_0000,  32'd4,          32'h0800_0000,  5);
    run("sll_0",     OP_SLL, 32'h0000_0001,  32'd0,          32'h0000_0001,  1);
    run("sll_31",    OP_SLL, 32'h0000_0001,  32'd31,         32'h8000_0000,  32);
    run("sra_pos_3", OP_SRA, 32'h4000_0000,  32'h0000_0023,  32'h0800_0000,  4);

    // Starts during a shift, with different operands, must be ignored.
    send("srl_8_ign", OP_SRL, 32'hABCD_0000, 32'd8, 32'h00AB_CD00, 9);
    @(negedge clk);
    start = 1'b1; op = OP_ADD; src_a = 32'd100; src_b = 32'd200;
    @(negedge clk);
    op = OP_SLL; src_a = 32'hFFFF_FFFF; src_b = 32'd1;
    @(negedge clk);
    op = OP_AND; src_a = 32'h0; src_b = 32'h0;
    @(negedge clk);
    start = 1'b0;
    drain("srl_8_ign");
    repeat (3) @(negedge clk);

    // Back-to-back issue in the done cycle: done on consecutive cycles.
    send("b2b_0", OP_ADD, 32'd1,  32'd1,         32'd2, 1);
    @(negedge clk);
    send("b2b_1", OP_ADD, 32'd2,  32'd2,         32'd4, 1);
    @(negedge clk);
    send("b2b_2", OP_ADD, 32'd10, 32'hFFFF_FFF6, 32'd0, 1);
    @(negedge clk);
    start = 1'b0;
    drain("b2b");
    @(negedge clk);
    run("pre_rst", OP_OR, 32'h0000_5A00, 32'h0000_00A5, 32'h0000_5AA5, 1);

    // Reset mid-shift: immediate abort, no done for the aborted op.
    start = 1'b1; op = OP_SLL; src_a = 32'h0000_0003; src_b = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL sll_10_busy got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    check_idle("mid_shift_reset");
    repeat (3) @(negedge clk);
    check_idle("reset_held");
    rst_n = 1'b1;
    run("post_rst", OP_ADD, 32'h0000_0100, 32'h0000_0023, 32'h0000_0123, 1);
    run("post_rst_sll", OP_SLL, 32'h0000_0003, 32'd2, 32'h0000_000C, 3);
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
